// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline stage: valid/ready op intake, req/ack data-memory port with watchdog, registered writeback.
// Optional build macro MEM_WB_MISALIGN_TRAP_EN turns misaligned accesses into an immediate error writeback.
module mem_wb_pipe #(
   parameter int DATA_W  = 32,
   parameter int RD_W    = 5,
   parameter int TIMEOUT = 15
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DATA_W-1:0]   in_aluout,
   input  logic [DATA_W-1:0]   in_busb,
   input  logic [2:0]          in_memop,
   input  logic                in_memtoreg,
   input  logic                in_memwr,
   input  logic                in_regwr,
   input  logic [RD_W-1:0]     in_rd,
   output logic                dmem_req,
   output logic                dmem_we,
   output logic [DATA_W-1:0]   dmem_addr,
   output logic [DATA_W-1:0]   dmem_wdata,
   output logic [DATA_W/8-1:0] dmem_wmask,
   input  logic [DATA_W-1:0]   dmem_rdata,
   input  logic                dmem_ack,
   output logic                wb_valid,
   output logic                wb_regwr,
   output logic [RD_W-1:0]     wb_rd,
   output logic [DATA_W-1:0]   wb_data,
   output logic                wb_err
);

   localparam int NB = DATA_W / 8;
   localparam int LB = $clog2(NB);

   typedef enum logic [0:0] {IDLE = 1'b0, ACCESS = 1'b1} state_t;

   state_t              state_r, state_s;
   logic [7:0]          cnt_r, cnt_s;
   logic                in_ready_r, in_ready_s;
   logic                dmem_req_r, dmem_req_s;
   logic                dmem_we_r, dmem_we_s;
   logic [DATA_W-1:0]   dmem_addr_r, dmem_addr_s;
   logic [DATA_W-1:0]   dmem_wdata_r, dmem_wdata_s;
   logic [NB-1:0]       dmem_wmask_r, dmem_wmask_s;
   logic [1:0]          ld_sz_r, ld_sz_s;
   logic                ld_uns_r, ld_uns_s;
   logic [LB-1:0]       ld_off_r, ld_off_s;
   logic                regwr_r, regwr_s;
   logic [RD_W-1:0]     rd_r, rd_s;
   logic                wb_valid_r, wb_valid_s;
   logic                wb_regwr_r, wb_regwr_s;
   logic [RD_W-1:0]     wb_rd_r, wb_rd_s;
   logic [DATA_W-1:0]   wb_data_r, wb_data_s;
   logic                wb_err_r, wb_err_s;

   logic [1:0]          sz_s;
   logic [LB-1:0]       off_s, low_s, off_al_s;
   logic                mis_s, is_mem_s;
   logic [DATA_W-1:0]   addr_al_s;

   // Mask of the address bits that must be zero for an access of 2**sz bytes.
   function automatic logic [LB-1:0] size_low(input logic [1:0] sz);
      logic [LB-1:0] m;
      m = '0;
      for (int b = 0; b < LB; b++) m[b] = (b < int'(sz));
      return m;
   endfunction

   function automatic logic [DATA_W-1:0] replicate(input logic [DATA_W-1:0] d, input logic [1:0] sz);
      logic [DATA_W-1:0] r;
      r = '0;
      for (int i = 0; i < NB; i++) begin
         case (sz)
            2'd0:    r[8*i +: 8] = d[7:0];
            2'd1:    r[8*i +: 8] = d[8*(i%2) +: 8];
            2'd2:    r[8*i +: 8] = d[8*(i%4) +: 8];
            default: r[8*i +: 8] = d[8*(i%8) +: 8];
         endcase
      end
      return r;
   endfunction

   function automatic logic [NB-1:0] lane_mask(input logic [1:0] sz, input logic [LB-1:0] off_al);
      logic [NB-1:0] m;
      m = '0;
      for (int i = 0; i < NB; i++)
         m[i] = (i >= int'(off_al)) && (i < int'(off_al) + (32'd1 << sz));
      return m;
   endfunction

   function automatic logic [DATA_W-1:0] load_ext(input logic [DATA_W-1:0] rdata, input logic [1:0] sz,
                                                  input logic [LB-1:0] off_al, input logic uns);
      logic [DATA_W-1:0] sh, r;
      int                nbits;
      logic              ext;
      sh    = rdata >> {off_al, 3'b000};
      nbits = 32'd8 << sz;
      ext   = ~uns & sh[nbits-1];
      r     = '0;
      for (int i = 0; i < DATA_W; i++) r[i] = (i < nbits) ? sh[i] : ext;
      return r;
   endfunction

   // Decode access size and lane alignment of the incoming op.
   always_comb begin
      sz_s = in_memop[1:0];
      if (DATA_W == 32 && in_memop[1:0] == 2'd3) begin
         sz_s = 2'd2;
      end else begin
         sz_s = in_memop[1:0];
      end
      off_s     = in_aluout[LB-1:0];
      low_s     = size_low(sz_s);
      off_al_s  = off_s & ~low_s;
      mis_s     = |(off_s & low_s);
      addr_al_s = {in_aluout[DATA_W-1:LB], off_al_s};
      is_mem_s  = in_memtoreg | in_memwr;
   end

   // Next-state and next-output logic; writeback is a one-cycle pulse.
   always_comb begin
      state_s      = state_r;
      cnt_s        = cnt_r;
      in_ready_s   = in_ready_r;
      dmem_req_s   = dmem_req_r;
      dmem_we_s    = dmem_we_r;
      dmem_addr_s  = dmem_addr_r;
      dmem_wdata_s = dmem_wdata_r;
      dmem_wmask_s = dmem_wmask_r;
      ld_sz_s      = ld_sz_r;
      ld_uns_s     = ld_uns_r;
      ld_off_s     = ld_off_r;
      regwr_s      = regwr_r;
      rd_s         = rd_r;
      wb_valid_s   = 1'b0;
      wb_regwr_s   = 1'b0;
      wb_err_s     = 1'b0;
      wb_rd_s      = wb_rd_r;
      wb_data_s    = wb_data_r;
      case (state_r)
         IDLE: begin
            if (in_valid) begin
               if (!is_mem_s) begin
                  wb_valid_s = 1'b1;
                  wb_regwr_s = in_regwr;
                  wb_rd_s    = in_rd;
                  wb_data_s  = in_aluout;
               end else
`ifdef MEM_WB_MISALIGN_TRAP_EN
               if (mis_s) begin
                  wb_valid_s = 1'b1;
                  wb_err_s   = 1'b1;
                  wb_rd_s    = in_rd;
                  wb_data_s  = in_aluout;
               end else
`endif
               begin
                  state_s      = ACCESS;
                  cnt_s        = 8'd0;
                  in_ready_s   = 1'b0;
                  dmem_req_s   = 1'b1;
                  dmem_we_s    = in_memwr;
                  dmem_addr_s  = addr_al_s;
                  dmem_wdata_s = in_memwr ? replicate(in_busb, sz_s) : '0;
                  dmem_wmask_s = in_memwr ? lane_mask(sz_s, off_al_s) : '0;
                  ld_sz_s      = sz_s;
                  ld_uns_s     = in_memop[2];
                  ld_off_s     = off_al_s;
                  regwr_s      = in_regwr;
                  rd_s         = in_rd;
               end
            end else begin
               in_ready_s = 1'b1;
            end
         end
         ACCESS: begin
            if (dmem_ack || cnt_r == 8'(TIMEOUT - 1)) begin
               state_s      = IDLE;
               in_ready_s   = 1'b1;
               dmem_req_s   = 1'b0;
               dmem_we_s    = 1'b0;
               dmem_wmask_s = '0;
               wb_valid_s   = 1'b1;
               wb_rd_s      = rd_r;
               if (dmem_ack) begin
                  wb_regwr_s = regwr_r & ~dmem_we_r;
                  wb_data_s  = dmem_we_r ? dmem_addr_r : load_ext(dmem_rdata, ld_sz_r, ld_off_r, ld_uns_r);
               end else begin
                  wb_err_s  = 1'b1;
                  wb_data_s = dmem_addr_r;
               end
            end else begin
               cnt_s = cnt_r + 8'd1;
            end
         end
         default: begin
            state_s    = IDLE;
            in_ready_s = 1'b1;
            dmem_req_s = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r      <= IDLE;
         cnt_r        <= 8'd0;
         in_ready_r   <= 1'b1;
         dmem_req_r   <= 1'b0;
         dmem_we_r    <= 1'b0;
         dmem_addr_r  <= '0;
         dmem_wdata_r <= '0;
         dmem_wmask_r <= '0;
         ld_sz_r      <= 2'd0;
         ld_uns_r     <= 1'b0;
         ld_off_r     <= '0;
         regwr_r      <= 1'b0;
         rd_r         <= '0;
         wb_valid_r   <= 1'b0;
         wb_regwr_r   <= 1'b0;
         wb_rd_r      <= '0;
         wb_data_r    <= '0;
         wb_err_r     <= 1'b0;
      end else begin
         state_r      <= state_s;
         cnt_r        <= cnt_s;
         in_ready_r   <= in_ready_s;
         dmem_req_r   <= dmem_req_s;
         dmem_we_r    <= dmem_we_s;
         dmem_addr_r  <= dmem_addr_s;
         dmem_wdata_r <= dmem_wdata_s;
         dmem_wmask_r <= dmem_wmask_s;
         ld_sz_r      <= ld_sz_s;
         ld_uns_r     <= ld_uns_s;
         ld_off_r     <= ld_off_s;
         regwr_r      <= regwr_s;
         rd_r         <= rd_s;
         wb_valid_r   <= wb_valid_s;
         wb_regwr_r   <= wb_regwr_s;
         wb_rd_r      <= wb_rd_s;
         wb_data_r    <= wb_data_s;
         wb_err_r     <= wb_err_s;
      end
   end

   assign in_ready   = in_ready_r;
   assign dmem_req   = dmem_req_r;
   assign dmem_we    = dmem_we_r;
   assign dmem_addr  = dmem_addr_r;
   assign dmem_wdata = dmem_wdata_r;
   assign dmem_wmask = dmem_wmask_r;
   assign wb_valid   = wb_valid_r;
   assign wb_regwr   = wb_regwr_r;
   assign wb_rd      = wb_rd_r;
   assign wb_data    = wb_data_r;
   assign wb_err     = wb_err_r;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Self-checking bench for mem_wb_pipe (DATA_W=32, TIMEOUT=15) with a behavioural byte-lane memory model.
module tb_mem_wb_pipe;
   localparam int TO = 15;

   logic        clock, reset;
   logic        in_valid, in_ready;
   logic [31:0] in_aluout, in_busb;
   logic [2:0]  in_memop;
   logic        in_memtoreg, in_memwr, in_regwr;
   logic [4:0]  in_rd;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_wmask;
   logic        dmem_ack;
   logic        wb_valid, wb_regwr, wb_err;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   int n_checks = 0;
   int n_fail   = 0;

   mem_wb_pipe #(.DATA_W(32), .RD_W(5), .TIMEOUT(TO)) dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_aluout(in_aluout), .in_busb(in_busb),
      .in_memop(in_memop), .in_memtoreg(in_memtoreg), .in_memwr(in_memwr), .in_regwr(in_regwr),
      .in_rd(in_rd),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_wmask(dmem_wmask), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
      .wb_valid(wb_valid), .wb_regwr(wb_regwr), .wb_rd(wb_rd), .wb_data(wb_data), .wb_err(wb_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Issue one op, act as memory with the given ack delay, and compare against the model.
   task automatic run_op(input logic [31:0] addr, input logic [31:0] busb, input logic [2:0] memop,
                         input logic ld, input logic st, input logic rw, input logic [4:0] rd,
                         input logic [31:0] rdata, input int ack_dly,
                         output logic [31:0] obs_addr, output logic [31:0] obs_wdata, output logic [3:0] obs_mask);
      int sz, bytes, off, al, n_req;
      bit is_mem, mis, trap, tmo;
      longint unsigned m, v, rep;
      logic [31:0] e_addr, e_data;
      logic [3:0]  e_mask;
      logic        e_regwr, e_err;
      is_mem = ld | st;
      sz = int'(memop[1:0]);
      if (sz == 3) sz = 2;
      bytes  = 1 << sz;
      off    = int'(addr % 32'd4);
      al     = off - (off % bytes);
      mis    = (off % bytes) != 0;
      e_addr = addr - (addr % 32'(bytes));
      m      = (64'd1 << (8 * bytes)) - 64'd1;
      rep    = 64'd0;
      for (int k = 0; k < 4 / bytes; k++) rep = rep | ((64'(busb) & m) << (8 * bytes * k));
      e_mask = 4'(((1 << bytes) - 1) << al);
      v      = (64'(rdata) >> (8 * al)) & m;
      if (!memop[2] && ((v >> (8 * bytes - 1)) & 64'd1) == 64'd1) v = v | ~m;
      trap = 1'b0;
`ifdef MEM_WB_MISALIGN_TRAP_EN
      trap = is_mem && mis;
`endif
      tmo = is_mem && !trap && (ack_dly >= TO);
      if (!is_mem) begin
         e_data = addr; e_regwr = rw; e_err = 1'b0;
      end else if (trap || tmo) begin
         e_data = trap ? addr : e_addr; e_regwr = 1'b0; e_err = 1'b1;
      end else if (st) begin
         e_data = 32'd0; e_regwr = 1'b0; e_err = 1'b0;
      end else begin
         e_data = v[31:0]; e_regwr = rw; e_err = 1'b0;
      end
      obs_addr = 32'd0; obs_wdata = 32'd0; obs_mask = 4'd0;

      @(negedge clock);
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL pre_ready got=%b exp=1", in_ready); end
      in_aluout = addr; in_busb = busb; in_memop = memop; in_memtoreg = ld; in_memwr = st;
      in_regwr = rw; in_rd = rd; in_valid = 1'b1;
      @(negedge clock);
      in_valid = 1'b0;
      if (is_mem && !trap) begin
         obs_addr = dmem_addr; obs_wdata = dmem_wdata; obs_mask = dmem_wmask;
         n_checks++; if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL req_start got=%b exp=1", dmem_req); end
         n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL busy_ready got=%b exp=0", in_ready); end
         n_checks++; if (dmem_addr !== e_addr) begin n_fail++; $display("FAIL dmem_addr got=%h exp=%h", dmem_addr, e_addr); end
         n_checks++; if (dmem_we !== st) begin n_fail++; $display("FAIL dmem_we got=%b exp=%b", dmem_we, st); end
         if (st) begin
            n_checks++; if (dmem_wdata !== rep[31:0]) begin n_fail++; $display("FAIL wdata got=%h exp=%h", dmem_wdata, rep[31:0]); end
            n_checks++; if (dmem_wmask !== e_mask) begin n_fail++; $display("FAIL wmask got=%b exp=%b", dmem_wmask, e_mask); end
         end
         n_req = 0;
         for (int c = 0; c < TO + 5; c++) begin
            if (dmem_req !== 1'b1) break;
            n_req++;
            dmem_ack   = (!tmo && c == ack_dly);
            dmem_rdata = dmem_ack ? rdata : $urandom;
            @(negedge clock);
         end
         dmem_ack = 1'b0;
         n_checks++;
         if (n_req != (tmo ? TO : ack_dly + 1)) begin
            n_fail++; $display("FAIL req_cycles got=%0d exp=%0d", n_req, tmo ? TO : ack_dly + 1);
         end
      end else begin
         n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL no_req got=%b exp=0", dmem_req); end
      end
      n_checks++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL wb_valid got=%b exp=1", wb_valid); end
      n_checks++; if (wb_err !== e_err) begin n_fail++; $display("FAIL wb_err got=%b exp=%b", wb_err, e_err); end
      n_checks++; if (wb_regwr !== e_regwr) begin n_fail++; $display("FAIL wb_regwr got=%b exp=%b", wb_regwr, e_regwr); end
      n_checks++; if (wb_rd !== rd) begin n_fail++; $display("FAIL wb_rd got=%0d exp=%0d", wb_rd, rd); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_ready got=%b exp=1", in_ready); end
      if (!(is_mem && st && !trap && !tmo)) begin
         n_checks++; if (wb_data !== e_data) begin n_fail++; $display("FAIL wb_data got=%h exp=%h", wb_data, e_data); end
      end
   endtask

   task automatic test_reset();
      in_valid = 1'b0; in_aluout = 32'd0; in_busb = 32'd0; in_memop = 3'd0; in_memtoreg = 1'b0;
      in_memwr = 1'b0; in_regwr = 1'b0; in_rd = 5'd0; dmem_rdata = 32'd0; dmem_ack = 1'b0;
      reset = 1'b0;
      repeat (2) @(negedge clock);
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got=%b exp=1", in_ready); end
      n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got=%b exp=0", dmem_req); end
      n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL rst_wbv got=%b exp=0", wb_valid); end
      n_checks++; if (wb_data !== 32'd0) begin n_fail++; $display("FAIL rst_wbd got=%h exp=0", wb_data); end
      n_checks++; if (dmem_addr !== 32'd0) begin n_fail++; $display("FAIL rst_addr got=%h exp=0", dmem_addr); end
      reset = 1'b1;
      @(negedge clock);
   endtask

   task automatic test_alu();
      logic [31:0] a, w; logic [3:0] mk;
      run_op(32'h1234, 32'd0, 3'd2, 1'b0, 1'b0, 1'b1, 5'd5, 32'd0, 0, a, w, mk);
      n_checks++; if (wb_data !== 32'h1234) begin n_fail++; $display("FAIL alu_data got=%h exp=1234", wb_data); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] pa; logic [4:0] pr; logic pw;
      pa = 32'd0; pr = 5'd0; pw = 1'b0;
      @(negedge clock);
      for (int i = 0; i < 8; i++) begin
         if (i > 0) begin
            n_checks++;
            if (wb_valid !== 1'b1 || wb_data !== pa || wb_rd !== pr || wb_regwr !== pw) begin
               n_fail++; $display("FAIL b2b got=%b/%h/%0d/%b exp=1/%h/%0d/%b", wb_valid, wb_data, wb_rd, wb_regwr, pa, pr, pw);
            end
         end
         n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got=%b exp=1", in_ready); end
         pa = $urandom; pr = 5'($urandom); pw = 1'($urandom);
         in_aluout = pa; in_rd = pr; in_regwr = pw; in_memtoreg = 1'b0; in_memwr = 1'b0; in_valid = 1'b1;
         @(negedge clock);
      end
      in_valid = 1'b0;
      n_checks++; if (wb_data !== pa || wb_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_last got=%h exp=%h", wb_data, pa); end
      @(negedge clock);
      n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL pulse_len got=%b exp=0", wb_valid); end
   endtask

   task automatic test_load_store();
      logic [31:0] a, w; logic [3:0] mk;
      run_op(32'h103, 32'd0, 3'b000, 1'b1, 1'b0, 1'b1, 5'd7, 32'h80FF_0000, 3, a, w, mk);
      n_checks++; if (wb_data !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb got=%h exp=ffffff80", wb_data); end
      run_op(32'h103, 32'd0, 3'b100, 1'b1, 1'b0, 1'b1, 5'd7, 32'h80FF_0000, 3, a, w, mk);
      n_checks++; if (wb_data !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu got=%h exp=00000080", wb_data); end
      run_op(32'h102, 32'hABCD_1234, 3'b001, 1'b0, 1'b1, 1'b1, 5'd9, 32'd0, 1, a, w, mk);
      n_checks++; if (mk !== 4'b1100) begin n_fail++; $display("FAIL sh_mask got=%b exp=1100", mk); end
      n_checks++; if (w !== 32'h1234_1234) begin n_fail++; $display("FAIL sh_wdata got=%h exp=12341234", w); end
      n_checks++; if (wb_regwr !== 1'b0) begin n_fail++; $display("FAIL sh_regwr got=%b exp=0", wb_regwr); end
   endtask

   task automatic test_timeout();
      logic [31:0] a, w; logic [3:0] mk;
      run_op(32'h200, 32'd0, 3'b010, 1'b1, 1'b0, 1'b1, 5'd3, 32'd0, TO + 10, a, w, mk);
      n_checks++; if (wb_err !== 1'b1 || wb_data !== 32'h200) begin n_fail++; $display("FAIL tmo got=%b/%h exp=1/200", wb_err, wb_data); end
   endtask

   task automatic test_late_ack();
      @(negedge clock);
      dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
      @(negedge clock);
      dmem_ack = 1'b0;
      n_checks++; if (wb_valid !== 1'b0 || dmem_req !== 1'b0) begin n_fail++; $display("FAIL late_ack got=%b/%b exp=0/0", wb_valid, dmem_req); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL late_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_reset_mid();
      @(negedge clock);
      in_aluout = 32'h300; in_memop = 3'b010; in_memtoreg = 1'b1; in_memwr = 1'b0; in_regwr = 1'b1; in_valid = 1'b1;
      @(negedge clock);
      in_valid = 1'b0;
      n_checks++; if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL mid_req got=%b exp=1", dmem_req); end
      @(negedge clock);
      #2 reset = 1'b0;
      #1;
      n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL mid_rst_req got=%b exp=0", dmem_req); end
      @(negedge clock);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         n_checks++;
         if (wb_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL mid_after got=%b/%b exp=0/1", wb_valid, in_ready);
         end
      end
   endtask

   task automatic test_misalign();
      logic [31:0] a, w; logic [3:0] mk;
      run_op(32'h101, 32'd0, 3'b010, 1'b1, 1'b0, 1'b1, 5'd4, 32'h1122_3344, 1, a, w, mk);
`ifdef MEM_WB_MISALIGN_TRAP_EN
      n_checks++; if (wb_err !== 1'b1 || wb_data !== 32'h101) begin n_fail++; $display("FAIL trap got=%b/%h exp=1/101", wb_err, wb_data); end
`else
      n_checks++; if (a !== 32'h100) begin n_fail++; $display("FAIL mis_addr got=%h exp=100", a); end
`endif
   endtask

   task automatic test_random();
      logic [31:0] a, w; logic [3:0] mk;
      int kind;
      for (int i = 0; i < 40; i++) begin
         kind = $urandom_range(0, 3);
         run_op($urandom, $urandom, 3'($urandom), kind == 1 || kind == 3, kind >= 2, 1'($urandom),
                5'($urandom), $urandom, $urandom_range(0, 4), a, w, mk);
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_back_to_back();
      test_load_store();
      test_timeout();
      test_late_ack();
      test_reset_mid();
      test_misalign();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
